ellipse_crop: RTL and testbench
===============================

// Module: ellipse_crop
// PURPOSE
//  Parametrised successor to circle_crop: masks pixels outside (or inside) a programmable
//  ellipse with independent centre and X/Y radii over NUM_CHAN channels. Sits in the
//  img_clk pixel pipeline between demosaic/colour stages and the output formatter.
//  Non-pixel dtypes and meta data pass through with identical, fixed latency.
// PARAMETERS
//  PIXEL_WIDTH  10  bits per channel
//  DIM_WIDTH    12  bits of row/column coordinate and of each config dimension
//  NUM_CHAN     3   channels packed on pixi/pixo, channel 0 in LSBs
// PORTS
//  clk         in   1                        pixel clock
//  reset       in   1                        async, active-high reset
//  enable      in   1                        0: pass-through (still 4-cycle latency)
//  mode        in   2                        0 bypass, 1 mask outside, 2 mask inside, 3 = 1
//  cx, cy      in   DIM_WIDTH                ellipse centre (column, row)
//  rx, ry      in   DIM_WIDTH                ellipse radii
//  fill        in   PIXEL_WIDTH              value written to every channel of masked pixels
//  dvi         in   1                        input data valid
//  dtypei      in   `DTYPE_WIDTH             input dtype
//  pixi        in   NUM_CHAN*PIXEL_WIDTH     input pixel
//  meta_datai  in   16                       input meta data
//  dvo         out  1                        output data valid
//  dtypeo      out  `DTYPE_WIDTH             output dtype
//  pixo        out  NUM_CHAN*PIXEL_WIDTH     output pixel
//  meta_datao  out  16                       output meta data
//  masked      out  1                        high with dvo when this pixel was replaced by fill
// BEHAVIOUR
//  Reset: dvo=0, dtypeo=0, pixo=0, meta_datao=0, masked=0; col/row counters=0;
//   shadow config (enable,mode,cx,cy,rx,ry,fill)=0, i.e. bypass until first frame start.
//  Config shadowing: on dvi & dtypei==`DTYPE_FRAME_START all config inputs are latched;
//   mid-frame input changes have no effect until the next FRAME_START.
//  Position: FRAME_START -> row=0,col=0. Each dvi pixel dtype (`DTYPE_PIXEL) uses current
//   (col,row), then col+1. ROW_END -> col=0,row+1. Counters saturate at 2^DIM_WIDTH-1.
//  Pipeline: 4 stages, every input field delayed exactly 4 clk cycles; dvo = dvi delayed 4.
//   S1: dx=col-cx, dy=row-cy (signed, DIM_WIDTH+1 bits).
//   S2: dx2=dx*dx, dy2=dy*dy, rx2=rx*rx, ry2=ry*ry (unsigned, 2*DIM_WIDTH+2 bits).
//   S3: a=dx2*ry2, b=dy2*rx2, c=rx2*ry2 (unsigned, 4*DIM_WIDTH+4 bits, no truncation).
//   S4: inside = (a+b <= c) computed at 4*DIM_WIDTH+5 bits; register outputs.
//  Masking rule at S4, pixel dtypes only: mask = shadow enable & ((mode odd-or-3 ? !inside
//   : mode==2 ? inside : 0)). If mask, every channel of pixo=fill and masked=1; else pixo=pixi
//   delayed, masked=0.
//  Boundary: pixel exactly on the ellipse (a+b==c) is inside. rx==0 or ry==0 -> inside=0
//   for all pixels (mode 1 masks whole frame, mode 2 masks nothing).
//  Non-pixel dtypes and dvi=0 cycles: pixo/meta/dtype pass delayed, masked=0, never filled.
//  Back-to-back: accepts one beat every cycle, no stalls; no ready handshake.
//  Reset mid-frame: pipeline contents discarded (dvo=0 next cycle), counters and shadow
//   config cleared; output stays bypass until next FRAME_START.
// TESTING
//  1 64x48 frame, cx=32 cy=24 rx=ry=10 mode=1 fill=0: (32,24),(42,24) pass, (43,24) masked=1
//    pixo=0; dvo exactly 4 cycles after each dvi.
//  2 Same frame mode=2 fill=0x3FF: (32,24) -> pixo all channels 0x3FF, (0,0) unchanged.
//  3 Ellipse rx=20 ry=5 at (32,24): (52,24) and (32,29) pass, (32,30) and (53,24) masked.
//  4 Change cx from 32 to 10 mid-frame: rest of frame uses 32; next frame uses 10.
//  5 rx=0 mode=1: every pixel masked; FRAME/ROW dtypes and meta_data pass unmodified.
//  6 Assert reset during row 10 of a mode-1 frame: dvo=0 next cycle; subsequent frame
//    without new FRAME_START config passes bypass; full frame afterwards masks correctly.

Source files
------------

// File: rtl/ellipse_crop_if.sv
// Pixel-stream bundle (valid, dtype, pixel, meta data) shared by the ellipse_crop input and output.
// The dtype codes are guarded so that any file in the bundle can also define them.
`ifndef ELLIPSE_CROP_DTYPES
`define ELLIPSE_CROP_DTYPES
`define DTYPE_WIDTH       4
`define DTYPE_PIXEL       4'd0
`define DTYPE_FRAME_START 4'd1
`define DTYPE_FRAME_END   4'd2
`define DTYPE_ROW_START   4'd3
`define DTYPE_ROW_END     4'd4
`endif

interface ellipse_crop_if #(
  parameter int unsigned PIXEL_WIDTH = 10,
  parameter int unsigned NUM_CHAN    = 3
);
  logic                            dv;
  logic [`DTYPE_WIDTH-1:0]         dtype;
  logic [NUM_CHAN*PIXEL_WIDTH-1:0] pix;
  logic [15:0]                     meta_data;

  modport master (output dv, dtype, pix, meta_data);
  modport slave  (input  dv, dtype, pix, meta_data);
endinterface

// File: rtl/ellipse_crop.sv
// Replaces pixels outside (or inside) a programmable ellipse with a fill value. All beats see a
// fixed 4-cycle latency; the configuration is sampled at each frame start.
module ellipse_crop #(
  parameter int unsigned PIXEL_WIDTH = 10,
  parameter int unsigned DIM_WIDTH   = 12,
  parameter int unsigned NUM_CHAN    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [DIM_WIDTH-1:0]   cx,
  input  logic [DIM_WIDTH-1:0]   cy,
  input  logic [DIM_WIDTH-1:0]   rx,
  input  logic [DIM_WIDTH-1:0]   ry,
  input  logic [PIXEL_WIDTH-1:0] fill,
  ellipse_crop_if.slave          in_bus,
  ellipse_crop_if.master         out_bus,
  output logic                   masked
);

  localparam int unsigned DW   = DIM_WIDTH;
  localparam int unsigned SW   = DW + 1;
  localparam int unsigned QW   = 2 * DW + 2;
  localparam int unsigned PW   = 4 * DW + 4;
  localparam int unsigned PIXW = NUM_CHAN * PIXEL_WIDTH;
  localparam logic [DW-1:0] DimMax = '1;

  logic                   sh_enable_q;
  logic [1:0]             sh_mode_q;
  logic [DW-1:0]          sh_cx_q, sh_cy_q, sh_rx_q, sh_ry_q;
  logic [PIXEL_WIDTH-1:0] sh_fill_q;
  logic [DW-1:0]          col_q, row_q;

  logic frame_start, is_pix, row_end;
  assign frame_start = in_bus.dv && (in_bus.dtype == `DTYPE_FRAME_START);
  assign is_pix      = in_bus.dv && (in_bus.dtype == `DTYPE_PIXEL);
  assign row_end     = in_bus.dv && (in_bus.dtype == `DTYPE_ROW_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_enable_q <= 1'b0;
      sh_mode_q   <= '0;
      sh_cx_q     <= '0;
      sh_cy_q     <= '0;
      sh_rx_q     <= '0;
      sh_ry_q     <= '0;
      sh_fill_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
    end else if (frame_start) begin
      sh_enable_q <= enable;
      sh_mode_q   <= mode;
      sh_cx_q     <= cx;
      sh_cy_q     <= cy;
      sh_rx_q     <= rx;
      sh_ry_q     <= ry;
      sh_fill_q   <= fill;
      col_q       <= '0;
      row_q       <= '0;
    end else if (is_pix) begin
      if (col_q != DimMax) col_q <= col_q + DW'(1);
    end else if (row_end) begin
      col_q <= '0;
      if (row_q != DimMax) row_q <= row_q + DW'(1);
    end
  end

  // Delay line for pass-through fields and per-beat mask controls; index 0 is S1, 2 is S3.
  logic [2:0]             dv_q, ispix_q, mout_q, min_q, nz_q;
  logic [`DTYPE_WIDTH-1:0] dtype_q [3];
  logic [PIXW-1:0]        pix_q   [3];
  logic [15:0]            meta_q  [3];
  logic [PIXEL_WIDTH-1:0] fill_q  [3];

  logic signed [SW-1:0] s1_dx_q, s1_dy_q;
  logic [DW-1:0]        s1_rx_q, s1_ry_q;
  logic [QW-1:0]        s2_dx2_q, s2_dy2_q, s2_rx2_q, s2_ry2_q;
  logic [PW-1:0]        s3_a_q, s3_b_q, s3_c_q;

  logic                   dvo_q, masked_q;
  logic [`DTYPE_WIDTH-1:0] dtypeo_q;
  logic [PIXW-1:0]        pixo_q;
  logic [15:0]            metao_q;

  // S1 differences
  logic signed [SW-1:0] dx_d, dy_d;
  assign dx_d = $signed({1'b0, col_q}) - $signed({1'b0, sh_cx_q});
  assign dy_d = $signed({1'b0, row_q}) - $signed({1'b0, sh_cy_q});

  // S2 squares; operands widened first so the products are computed at full width
  logic signed [QW-1:0] dx_w, dy_w;
  logic [QW-1:0]        rx_w, ry_w, dx2_d, dy2_d, rx2_d, ry2_d;
  assign dx_w  = QW'(s1_dx_q);
  assign dy_w  = QW'(s1_dy_q);
  assign rx_w  = QW'(s1_rx_q);
  assign ry_w  = QW'(s1_ry_q);
  assign dx2_d = dx_w * dx_w;
  assign dy2_d = dy_w * dy_w;
  assign rx2_d = rx_w * rx_w;
  assign ry2_d = ry_w * ry_w;

  // S3 cross products
  logic [PW-1:0] a_d, b_d, c_d;
  assign a_d = PW'(s2_dx2_q) * PW'(s2_ry2_q);
  assign b_d = PW'(s2_dy2_q) * PW'(s2_rx2_q);
  assign c_d = PW'(s2_rx2_q) * PW'(s2_ry2_q);

  // S4 decision; a zero radius would make c=0 and wrongly admit the centre, hence nz
  logic [PW:0]     sum_d;
  logic            inside_d, mask_d;
  logic [PIXW-1:0] pixo_d;
  always_comb begin
    sum_d    = (PW + 1)'(s3_a_q) + (PW + 1)'(s3_b_q);
    inside_d = nz_q[2] && (sum_d <= (PW + 1)'(s3_c_q));
    mask_d   = ispix_q[2] && ((mout_q[2] && !inside_d) || (min_q[2] && inside_d));
    pixo_d   = mask_d ? {NUM_CHAN{fill_q[2]}} : pix_q[2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_q     <= '0;
      ispix_q  <= '0;
      mout_q   <= '0;
      min_q    <= '0;
      nz_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        dtype_q[i] <= '0;
        pix_q[i]   <= '0;
        meta_q[i]  <= '0;
        fill_q[i]  <= '0;
      end
      s1_dx_q  <= '0;
      s1_dy_q  <= '0;
      s1_rx_q  <= '0;
      s1_ry_q  <= '0;
      s2_dx2_q <= '0;
      s2_dy2_q <= '0;
      s2_rx2_q <= '0;
      s2_ry2_q <= '0;
      s3_a_q   <= '0;
      s3_b_q   <= '0;
      s3_c_q   <= '0;
      dvo_q    <= 1'b0;
      dtypeo_q <= '0;
      pixo_q   <= '0;
      metao_q  <= '0;
      masked_q <= 1'b0;
    end else begin
      dv_q    <= {dv_q[1:0], in_bus.dv};
      ispix_q <= {ispix_q[1:0], is_pix};
      mout_q  <= {mout_q[1:0], sh_enable_q & sh_mode_q[0]};
      min_q   <= {min_q[1:0], sh_enable_q & (sh_mode_q == 2'd2)};
      nz_q    <= {nz_q[1:0], (sh_rx_q != '0) && (sh_ry_q != '0)};
      dtype_q[0] <= in_bus.dtype;
      pix_q[0]   <= in_bus.pix;
      meta_q[0]  <= in_bus.meta_data;
      fill_q[0]  <= sh_fill_q;
      for (int i = 1; i < 3; i++) begin
        dtype_q[i] <= dtype_q[i-1];
        pix_q[i]   <= pix_q[i-1];
        meta_q[i]  <= meta_q[i-1];
        fill_q[i]  <= fill_q[i-1];
      end
      s1_dx_q  <= dx_d;
      s1_dy_q  <= dy_d;
      s1_rx_q  <= sh_rx_q;
      s1_ry_q  <= sh_ry_q;
      s2_dx2_q <= dx2_d;
      s2_dy2_q <= dy2_d;
      s2_rx2_q <= rx2_d;
      s2_ry2_q <= ry2_d;
      s3_a_q   <= a_d;
      s3_b_q   <= b_d;
      s3_c_q   <= c_d;
      dvo_q    <= dv_q[2];
      dtypeo_q <= dtype_q[2];
      pixo_q   <= pixo_d;
      metao_q  <= meta_q[2];
      masked_q <= mask_d;
    end
  end

  assign out_bus.dv        = dvo_q;
  assign out_bus.dtype     = dtypeo_q;
  assign out_bus.pix       = pixo_q;
  assign out_bus.meta_data = metao_q;
  assign masked            = masked_q;

endmodule

// File: tb/tb_ellipse_crop.sv
// Scoreboard bench for ellipse_crop: stimulus pushes expected beats, a monitor pops and compares.
`ifndef ELLIPSE_CROP_DTYPES
`define ELLIPSE_CROP_DTYPES
`define DTYPE_WIDTH       4
`define DTYPE_PIXEL       4'd0
`define DTYPE_FRAME_START 4'd1
`define DTYPE_FRAME_END   4'd2
`define DTYPE_ROW_START   4'd3
`define DTYPE_ROW_END     4'd4
`endif

module tb_ellipse_crop;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] cx, cy, rx, ry;
  logic [9:0]  fill;
  logic        masked;

  ellipse_crop_if #(.PIXEL_WIDTH(10), .NUM_CHAN(3)) in_if ();
  ellipse_crop_if #(.PIXEL_WIDTH(10), .NUM_CHAN(3)) out_if ();

  ellipse_crop #(.PIXEL_WIDTH(10), .DIM_WIDTH(12), .NUM_CHAN(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .cx     (cx),
    .cy     (cy),
    .rx     (rx),
    .ry     (ry),
    .fill   (fill),
    .in_bus (in_if),
    .out_bus(out_if),
    .masked (masked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0]  dtype;
    logic [29:0] pix;
    logic [15:0] meta;
    logic        msk;
    int          t;
  } exp_t;
  exp_t q[$];

  // Hand-computed expectations at named coordinates, keyed by frame id.
  typedef struct { int tid; int c; int r; bit m; } hand_t;
  localparam int NH = 18;
  hand_t hand [NH] = '{
    '{1, 32, 24, 1'b0}, '{1, 42, 24, 1'b0}, '{1, 43, 24, 1'b1},
    '{2, 32, 24, 1'b1}, '{2,  0,  0, 1'b0},
    '{3, 52, 24, 1'b0}, '{3, 32, 29, 1'b0}, '{3, 32, 30, 1'b1}, '{3, 53, 24, 1'b1},
    '{4, 32, 30, 1'b0},
    '{5, 32, 30, 1'b1}, '{5, 10, 24, 1'b0},
    '{6, 32, 24, 1'b1}, '{6,  0,  0, 1'b1},
    '{8,  0,  0, 1'b0}, '{8, 43, 24, 1'b0},
    '{9, 43, 24, 1'b1}, '{9, 32, 24, 1'b0}
  };

  // Reference state: config captured at frame start and pixel position.
  bit       m_en;
  int       m_mode, m_cx, m_cy, m_rx, m_ry;
  logic [9:0] m_fill;
  int       mcol, mrow;

  function automatic bit ref_inside(input int c, r, ccx, ccy, rrx, rry);
    longint dx, dy, a, b, cc;
    if (rrx == 0 || rry == 0) return 1'b0;
    dx = c - ccx;
    dy = r - ccy;
    a  = dx * dx * rry * rry;
    b  = dy * dy * rrx * rrx;
    cc = longint'(rrx) * rrx * rry * rry;
    return (a + b) <= cc;
  endfunction

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_cx = 0; m_cy = 0; m_rx = 0; m_ry = 0; m_fill = '0;
    mcol = 0; mrow = 0;
  endtask

  task automatic beat(input int tid, input logic [3:0] dt, input logic [29:0] p,
                      input logic [15:0] mt);
    exp_t e;
    bit   m;
    in_if.dv = 1'b1; in_if.dtype = dt; in_if.pix = p; in_if.meta_data = mt;
    e.dtype = dt; e.pix = p; e.meta = mt; e.msk = 1'b0; e.t = cyc;
    if (dt == `DTYPE_FRAME_START) begin
      m_en = enable; m_mode = mode; m_cx = cx; m_cy = cy; m_rx = rx; m_ry = ry; m_fill = fill;
      mcol = 0; mrow = 0;
    end else if (dt == `DTYPE_PIXEL) begin
      bit ins;
      ins = ref_inside(mcol, mrow, m_cx, m_cy, m_rx, m_ry);
      m = m_en && ((m_mode == 1 || m_mode == 3) ? !ins : (m_mode == 2 ? ins : 1'b0));
      for (int i = 0; i < NH; i++)
        if (hand[i].tid == tid && hand[i].c == mcol && hand[i].r == mrow) m = hand[i].m;
      e.msk = m;
      e.pix = m ? {3{m_fill}} : p;
      if (mcol < 4095) mcol++;
    end else if (dt == `DTYPE_ROW_END) begin
      mcol = 0;
      if (mrow < 4095) mrow++;
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_if.dv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cfg(input bit en, input int md, input int ccx, ccy, rrx, rry, input int fl);
    enable = en; mode = 2'(md); cx = 12'(ccx); cy = 12'(ccy); rx = 12'(rrx); ry = 12'(rry);
    fill = 10'(fl);
  endtask

  task automatic frame(input int tid, input bit fs, input int chg_row, input int chg_cx,
                       input int rst_row);
    if (fs) beat(tid, `DTYPE_FRAME_START, 30'h2AA_5555, 16'(32'hF000 + tid));
    for (int r = 0; r < 48; r++) begin
      if (r == chg_row) cx = 12'(chg_cx);
      for (int c = 0; c < 64; c++) begin
        if (r == rst_row && c == 20) begin
          reset = 1'b1;
          in_if.dv = 1'b0;
          #1;
          chk("rst_dvo", {63'd0, out_if.dv}, 64'd0);
          q.delete();
          model_reset();
          @(posedge clk); #1;
          reset = 1'b0;
          idle();
          return;
        end
        beat(tid, `DTYPE_PIXEL, {10'(c + r + 1), 10'(r), 10'(c)}, {8'(r), 8'(c)});
      end
      beat(tid, `DTYPE_ROW_END, 30'h155_0F0F, 16'(32'hE000 + r));
      idle();
    end
    beat(tid, `DTYPE_FRAME_END, 30'h0AB_CDEF, 16'(32'hD000 + tid));
  endtask

  // Monitor: every valid output beat must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_if.dv === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          chk("dtype", 64'(out_if.dtype), 64'(e.dtype));
          chk("pix", 64'(out_if.pix), 64'(e.pix));
          chk("meta", 64'(out_if.meta_data), 64'(e.meta));
          chk("masked", 64'(masked), 64'(e.msk));
          chk("latency", 64'(cyc - e.t), 64'd4);
        end
      end else if (reset === 1'b0) begin
        chk("idle_masked", 64'(masked), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_if.dv = 1'b0; in_if.dtype = '0; in_if.pix = '0; in_if.meta_data = '0;
    cfg(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dvo", 64'(out_if.dv), 64'd0);
    chk("rst_dtypeo", 64'(out_if.dtype), 64'd0);
    chk("rst_pixo", 64'(out_if.pix), 64'd0);
    chk("rst_meta", 64'(out_if.meta_data), 64'd0);
    chk("rst_masked", 64'(masked), 64'd0);
    reset = 1'b0;
    idle();
    idle();

    cfg(1, 1, 32, 24, 10, 10, 0);      frame(1, 1, -1, 0, -1);
    cfg(1, 2, 32, 24, 10, 10, 10'h3FF); frame(2, 1, -1, 0, -1);
    cfg(1, 1, 32, 24, 20, 5, 0);       frame(3, 1, -1, 0, -1);
    cfg(1, 1, 32, 24, 10, 10, 0);      frame(4, 1, 24, 10, -1);
    frame(5, 1, -1, 0, -1);
    cfg(1, 1, 32, 24, 0, 10, 10'h155); frame(6, 1, -1, 0, -1);
    cfg(1, 1, 32, 24, 10, 10, 0);      frame(7, 1, -1, 0, 10);
    frame(8, 0, -1, 0, -1);
    frame(9, 1, -1, 0, -1);

    in_if.dv = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
